// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg
//  Shared types and helpers for the SPI master transaction controller.
//  spi_ctrl_state_t : FSM state encoding used by spi_master_ctrl
//  cnt_width()      : width of a counter that must hold 0..word_w
package spi_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      SHIFT   = 2'd2,
      CAPTURE = 2'd3
   } spi_ctrl_state_t;

   function automatic int cnt_width(input int word_w);
      return $clog2(word_w + 1);
   endfunction

endpackage

// File: rtl/spi_ctrl_fifo.sv
// spi_ctrl_fifo
//  Synchronous FIFO holding queued {ss, data} words for the SPI controller.
//  Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_data, wr_en  write port; a write while full is accepted only if a read
//                   happens in the same cycle
//   rd_en           pop the head entry (ignored when empty)
//   rd_data         head entry (valid while !empty)
//   full, empty     occupancy flags
module spi_ctrl_fifo
   import spi_ctrl_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         if (do_wr && !do_rd)      count <= count + (AW+1)'(1);
         else if (!do_wr && do_rd) count <= count - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//  Transaction controller sitting upstream of a master-mode SPI core. Queues
//  outgoing words, drives the core's WE/SSE/SE/SSV/D_IN per word, counts the
//  shift cycles and hands the received word downstream on a valid/ready port.
//  Optional macro SPI_CTRL_IRQ_EN adds an end-of-burst irq pulse output.
//  Ports:
//   clk, rst                       clock (also the core's SCLK), async active-high reset
//   tx_data, tx_ss, tx_valid,
//   tx_ready                       word input; tx_ready = room in FIFO after this cycle's pop
//   cfg_se                         sync edge select, sampled when a word is loaded
//   rx_data, rx_valid, rx_ready    received word output
//   busy                           FIFO non-empty or FSM active
//   spi_we, spi_sse, spi_se,
//   spi_ssv, spi_d_in              registered controls to the SPI core
//   spi_d_out                      received word from the SPI core
//   irq                            end-of-burst pulse (only with SPI_CTRL_IRQ_EN)
//
//  state   | meaning
//  IDLE    | nothing queued, core idle
//  LOAD    | one cycle: core WE pulsed with the FIFO head, counter preset
//  SHIFT   | SSE high for exactly WORD_W cycles
//  CAPTURE | SSE low; latch D_OUT into rx holding reg, stall while it is full
module spi_master_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int WORD_W     = 8,
   parameter int SS_W       = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] tx_data,
   input  logic [SS_W-1:0]   tx_ss,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              cfg_se,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              spi_we,
   output logic              spi_sse,
   output logic              spi_se,
   output logic [SS_W-1:0]   spi_ssv,
   output logic [WORD_W-1:0] spi_d_in,
`ifdef SPI_CTRL_IRQ_EN
   output logic              irq,
`endif
   input  logic [WORD_W-1:0] spi_d_out
);

   localparam int CW = cnt_width(WORD_W);

   spi_ctrl_state_t         state;
   logic [CW-1:0]           bit_cnt;
   logic [SS_W+WORD_W-1:0]  fifo_head;
   logic [WORD_W-1:0]       head_data;
   logic [SS_W-1:0]         head_ss;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    capture_ok;
   logic                    pop;
   logic                    push;

   assign head_data  = fifo_head[WORD_W-1:0];
   assign head_ss    = fifo_head[SS_W+WORD_W-1:WORD_W];
   assign capture_ok = !rx_valid || rx_ready;

   // Pop coincides with the transition into LOAD.
   always_comb begin
      pop = 1'b0;
      unique case (state)
         IDLE:    pop = !fifo_empty;
         CAPTURE: pop = capture_ok && !fifo_empty;
         default: pop = 1'b0;
      endcase
   end

   // A full FIFO still takes a word in the cycle it pops.
   assign tx_ready = !fifo_full || pop;
   assign push     = tx_valid && tx_ready;
   assign busy     = !fifo_empty || (state != IDLE);

   spi_ctrl_fifo #(
      .WIDTH (SS_W + WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_data ({tx_ss, tx_data}),
      .wr_en   (push),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         spi_we   <= 1'b0;
         spi_sse  <= 1'b0;
         spi_se   <= 1'b0;
         spi_ssv  <= '0;
         spi_d_in <= '0;
`ifdef SPI_CTRL_IRQ_EN
         irq      <= 1'b0;
`endif
      end else begin
         spi_we <= 1'b0;
`ifdef SPI_CTRL_IRQ_EN
         irq    <= 1'b0;
`endif
         // A capture below overrides this drop.
         if (rx_valid && rx_ready) rx_valid <= 1'b0;

         unique case (state)
            IDLE: ;
            LOAD: begin
               state   <= SHIFT;
               spi_sse <= 1'b1;
            end
            SHIFT: begin
               bit_cnt <= bit_cnt - CW'(1);
               if (bit_cnt == CW'(1)) begin
                  state   <= CAPTURE;
                  spi_sse <= 1'b0;
               end
            end
            CAPTURE: begin
               if (capture_ok) begin
                  rx_data  <= spi_d_out;
                  rx_valid <= 1'b1;
                  if (fifo_empty) begin
                     state <= IDLE;
`ifdef SPI_CTRL_IRQ_EN
                     irq   <= 1'b1;
`endif
                  end
               end
            end
         endcase

         // Core-side word settings only change here, so SSV/SE/D_IN stay
         // frozen for the whole shift and capture of a word.
         if (pop) begin
            state    <= LOAD;
            spi_we   <= 1'b1;
            spi_d_in <= head_data;
            spi_ssv  <= head_ss;
            spi_se   <= cfg_se;
            bit_cnt  <= CW'(WORD_W);
         end
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

   localparam int WORD_W = 8;
   localparam logic [7:0] SLAVE_XOR = 8'h99;   // bench slave returns tx ^ 0x99

   typedef struct {
      logic [7:0] data;
      logic [1:0] ss;
      logic       se;
      logic [7:0] exp_rx;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic [1:0] tx_ss;
   logic       tx_valid;
   logic       tx_ready;
   logic       cfg_se;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       busy;
   logic       spi_we;
   logic       spi_sse;
   logic       spi_se;
   logic [1:0] spi_ssv;
   logic [7:0] spi_d_in;
   logic [7:0] spi_d_out;
`ifdef SPI_CTRL_IRQ_EN
   logic       irq;
   int         n_irq;
`endif

   int passed;
   int total;
   int cyc;
   int n_load;
   int n_sse;
   int hold_bad;
   int load_cyc[$];
   logic [7:0] rx_q[$];
   logic [1:0] prev_ssv;
   logic       prev_se;
   logic [7:0] prev_din;

   spi_master_ctrl #(.WORD_W(8), .SS_W(2), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data),
      .tx_ss     (tx_ss),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .cfg_se    (cfg_se),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .busy      (busy),
      .spi_we    (spi_we),
      .spi_sse   (spi_sse),
      .spi_se    (spi_se),
      .spi_ssv   (spi_ssv),
      .spi_d_in  (spi_d_in),
`ifdef SPI_CTRL_IRQ_EN
      .irq       (irq),
`endif
      .spi_d_out (spi_d_out)
   );

   assign spi_d_out = spi_d_in ^ SLAVE_XOR;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Advance one clock, sample 1ns after the edge and update the monitors.
   task automatic tick();
      if (rx_valid && rx_ready) rx_q.push_back(rx_data);
      @(posedge clk);
      #1;
      cyc++;
      if (spi_we) begin
         n_load++;
         load_cyc.push_back(cyc);
      end
      if (spi_sse) n_sse++;
      if (spi_we && spi_sse) hold_bad++;
      if (!spi_we && (spi_ssv != prev_ssv || spi_se != prev_se || spi_d_in != prev_din))
         hold_bad++;
      prev_ssv = spi_ssv;
      prev_se  = spi_se;
      prev_din = spi_d_in;
`ifdef SPI_CTRL_IRQ_EN
      if (irq) n_irq++;
`endif
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int t, l0, s0, first_load, first_sse;
      tx_data  = v.data;
      tx_ss    = v.ss;
      cfg_se   = v.se;
      rx_ready = 1'b1;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      l0 = n_load;
      s0 = n_sse;
      first_load = -1;
      first_sse  = -1;
      t = 0;
      while (!rx_valid && t < 40) begin
         tick();
         t++;
         if (spi_we && first_load < 0)  first_load = t;
         if (spi_sse && first_sse < 0)  first_sse = t;
      end
      check({nm, "_latency"},    t, WORD_W + 3);
      check({nm, "_rx_data"},    32'(rx_data), 32'(v.exp_rx));
      check({nm, "_loads"},      n_load - l0, 1);
      check({nm, "_sse_cycles"}, n_sse - s0, WORD_W);
      check({nm, "_first_load"}, first_load, 1);
      check({nm, "_first_sse"},  first_sse, 2);
      check({nm, "_ssv"},        32'(spi_ssv), 32'(v.ss));
      check({nm, "_se"},         32'(spi_se), 32'(v.se));
      check({nm, "_d_in"},       32'(spi_d_in), 32'(v.data));
      tick();
      check({nm, "_rx_drop"},    32'(rx_valid), 0);
      check({nm, "_idle"},       32'(busy), 0);
   endtask

   initial begin
      vec_t       vecs[4];
      logic [7:0] bw[6];
      int t, r0, l0, s0, lc0, gap_bad;

      vecs[0] = '{8'hA5, 2'b01, 1'b0, 8'h3C};
      vecs[1] = '{8'h00, 2'b10, 1'b1, 8'h99};
      vecs[2] = '{8'hFF, 2'b11, 1'b0, 8'h66};
      vecs[3] = '{8'h5A, 2'b00, 1'b1, 8'hC3};
      bw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      passed = 0; total = 0; cyc = 0; n_load = 0; n_sse = 0; hold_bad = 0;
      prev_ssv = '0; prev_se = 1'b0; prev_din = '0;
`ifdef SPI_CTRL_IRQ_EN
      n_irq = 0;
`endif
      rst = 1'b1; tx_data = '0; tx_ss = '0; tx_valid = 1'b0; cfg_se = 1'b0; rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_rx_data",  32'(rx_data), 0);
      check("rst_we",       32'(spi_we), 0);
      check("rst_sse",      32'(spi_sse), 0);
      check("rst_se",       32'(spi_se), 0);
      check("rst_ssv",      32'(spi_ssv), 0);
      check("rst_d_in",     32'(spi_d_in), 0);
      check("rst_busy",     32'(busy), 0);
      check("rst_tx_ready", 32'(tx_ready), 1);
`ifdef SPI_CTRL_IRQ_EN
      check("rst_irq",      32'(irq), 0);
`endif
      rst = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Burst: the first word is popped straight away, so five pushes fill
      // the four-entry FIFO; a sixth is pushed in the pop cycle while full.
      rx_ready = 1'b1; cfg_se = 1'b0;
      r0 = rx_q.size(); lc0 = load_cyc.size();
      for (int i = 0; i < 5; i++) begin
         tx_data = bw[i]; tx_ss = 2'(i); tx_valid = 1'b1;
         tick();
      end
      tx_valid = 1'b0;
      check("burst_full_tx_ready", 32'(tx_ready), 0);
      check("burst_busy", 32'(busy), 1);
      t = 0;
      while ((spi_we || spi_sse) && t < 40) begin tick(); t++; end
      check("burst_pop_tx_ready", 32'(tx_ready), 1);
      tx_data = bw[5]; tx_ss = 2'd1; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check("burst_refill_tx_ready", 32'(tx_ready), 0);
      t = 0;
      while (rx_q.size() - r0 < 6 && t < 200) begin tick(); t++; end
      check("burst_rx_count", rx_q.size() - r0, 6);
      if (rx_q.size() - r0 >= 6)
         for (int i = 0; i < 6; i++)
            check($sformatf("burst_rx%0d", i), 32'(rx_q[r0 + i]), 32'(bw[i] ^ SLAVE_XOR));
      check("burst_load_count", load_cyc.size() - lc0, 6);
      gap_bad = 0;
      for (int i = 1; i < 6; i++)
         if (lc0 + i >= load_cyc.size() || load_cyc[lc0 + i] - load_cyc[lc0 + i - 1] != WORD_W + 2)
            gap_bad++;
      check("burst_load_gap", gap_bad, 0);
      tick();
      check("burst_end_idle", 32'(busy), 0);

      // Backpressure: second word stalls in CAPTURE while the first is held.
      rx_ready = 1'b0;
      l0 = n_load; s0 = n_sse; r0 = rx_q.size();
      tx_data = 8'hC0; tx_ss = 2'd2; tx_valid = 1'b1; tick();
      tx_data = 8'h0D; tx_ss = 2'd3; tick();
      tx_valid = 1'b0;
      repeat (35) tick();
      check("bp_rx_valid",  32'(rx_valid), 1);
      check("bp_rx_held",   32'(rx_data), 32'(8'hC0 ^ SLAVE_XOR));
      check("bp_sse_low",   32'(spi_sse), 0);
      check("bp_busy",      32'(busy), 1);
      check("bp_loads",     n_load - l0, 2);
      check("bp_sse_total", n_sse - s0, 2 * WORD_W);
      rx_ready = 1'b1;
      tick();
      check("bp_release_valid", 32'(rx_valid), 1);
      check("bp_release_data",  32'(rx_data), 32'(8'h0D ^ SLAVE_XOR));
      check("bp_release_idle",  32'(busy), 0);
      tick();
      check("bp_rx_count", rx_q.size() - r0, 2);
      if (rx_q.size() - r0 >= 2) begin
         check("bp_order0", 32'(rx_q[r0]),     32'(8'hC0 ^ SLAVE_XOR));
         check("bp_order1", 32'(rx_q[r0 + 1]), 32'(8'h0D ^ SLAVE_XOR));
      end
      check("bp_rx_drop", 32'(rx_valid), 0);

      // Reset at the fourth SHIFT cycle with a second word still queued.
      s0 = n_sse; r0 = rx_q.size();
      tx_data = 8'h77; tx_ss = 2'd1; tx_valid = 1'b1; tick();
      tx_data = 8'h88; tick();
      tx_valid = 1'b0;
      t = 0;
      while (n_sse - s0 < 4 && t < 20) begin tick(); t++; end
      check("rst_mid_sse_before", 32'(spi_sse), 1);
      rst = 1'b1;
      #1;
      check("rst_mid_sse_async", 32'(spi_sse), 0);
      check("rst_mid_we",        32'(spi_we), 0);
      #10;
      rst = 1'b0;
      prev_ssv = '0; prev_se = 1'b0; prev_din = '0;
      l0 = n_load;
      repeat (3) tick();
      check("rst_mid_rx_valid", 32'(rx_valid), 0);
      check("rst_mid_busy",     32'(busy), 0);
      check("rst_mid_tx_ready", 32'(tx_ready), 1);
      check("rst_mid_no_load",  n_load - l0, 0);
      check("rst_mid_no_rx",    rx_q.size() - r0, 0);

      // SS / sync-edge change between two queued words.
      r0 = rx_q.size();
      cfg_se = 1'b0;
      tx_data = 8'h3E; tx_ss = 2'd1; tx_valid = 1'b1; tick();
      tx_data = 8'hE3; tx_ss = 2'd2; tick();
      tx_valid = 1'b0;
      cfg_se = 1'b1;
      tick();
      check("ss_w0_sse", 32'(spi_sse), 1);
      check("ss_w0_se",  32'(spi_se), 0);
      check("ss_w0_ssv", 32'(spi_ssv), 1);
      t = 0;
      while (rx_q.size() - r0 < 2 && t < 60) begin tick(); t++; end
      check("ss_rx_count", rx_q.size() - r0, 2);
      check("ss_w1_ssv", 32'(spi_ssv), 2);
      check("ss_w1_se",  32'(spi_se), 1);
      if (rx_q.size() - r0 >= 2)
         check("ss_rx1", 32'(rx_q[r0 + 1]), 32'(8'hE3 ^ SLAVE_XOR));
      check("ssv_se_din_hold", hold_bad, 0);
      cfg_se = 1'b0;

`ifdef SPI_CTRL_IRQ_EN
      begin
         int i0;
         i0 = n_irq; r0 = rx_q.size();
         rx_ready = 1'b1;
         for (int i = 0; i < 3; i++) begin
            tx_data = bw[i]; tx_ss = 2'd1; tx_valid = 1'b1; tick();
         end
         tx_valid = 1'b0;
         t = 0;
         while (n_irq == i0 && t < 100) begin tick(); t++; end
         check("irq_seen",       n_irq - i0, 1);
         check("irq_with_last",  32'(rx_valid), 1);
         check("irq_last_data",  32'(rx_data), 32'(bw[2] ^ SLAVE_XOR));
         check("irq_prior_rx",   rx_q.size() - r0, 2);
         repeat (3) tick();
         check("irq_single",     n_irq - i0, 1);
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
